// File: rtl/alu_ex_stage.sv
// Execute stage for the 16-bit WISC datapath.
// Saturating ADD/SUB, XOR, SLL/SRA through the Shifter, and ROR, all with a registered result and Z/V/N flags.

module Shifter (
  input  logic [15:0] Shift_In,
  input  logic [3:0]  Shift_Val,
  input  logic        Mode,
  output logic [15:0] Shift_Out
);

  logic        fill;
  logic [15:0] s1, s2, s4;

  // Log-depth barrel: Mode=0 is a logical left shift, Mode=1 is an arithmetic right shift.
  always_comb begin
    fill = Mode & Shift_In[15];
    if (!Shift_Val[0])  s1 = Shift_In;
    else if (Mode)      s1 = {fill, Shift_In[15:1]};
    else                s1 = {Shift_In[14:0], 1'b0};
    if (!Shift_Val[1])  s2 = s1;
    else if (Mode)      s2 = {{2{fill}}, s1[15:2]};
    else                s2 = {s1[13:0], 2'b0};
    if (!Shift_Val[2])  s4 = s2;
    else if (Mode)      s4 = {{4{fill}}, s2[15:4]};
    else                s4 = {s2[11:0], 4'b0};
    if (!Shift_Val[3])  Shift_Out = s4;
    else if (Mode)      Shift_Out = {{8{fill}}, s4[15:8]};
    else                Shift_Out = {s4[7:0], 8'b0};
  end

endmodule

module alu_ex_stage #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic [3:0]       shamt,
  output logic             ex_valid,
  output logic [WIDTH-1:0] ex_result,
  output logic [3:0]       ex_opcode,
  output logic             ZF,
  output logic             VF,
  output logic             NF,
  output logic             illegal_op
);

  localparam int unsigned MSB = WIDTH - 1;
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;
  localparam logic [3:0] OP_ROR = 4'b0110;
  localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic             ex_valid_q, ex_valid_d;
  logic [WIDTH-1:0] ex_result_q, ex_result_d;
  logic [3:0]       ex_opcode_q, ex_opcode_d;
  logic             zf_q, zf_d, vf_q, vf_d, nf_q, nf_d;
  logic             illegal_op_q, illegal_op_d;

  logic [WIDTH-1:0] sum, diff, ror_res, shift_res, alu_res;
  logic             add_ovf, sub_ovf, alu_ovf, is_arith, legal;

  Shifter u_shifter (
    .Shift_In  (srcA),
    .Shift_Val (shamt),
    .Mode      (opcode == OP_SRA),
    .Shift_Out (shift_res)
  );

  // Combinational ALU; overflow is detected from operand and raw result sign bits.
  always_comb begin
    sum      = srcA + srcB;
    diff     = srcA - srcB;
    add_ovf  = (srcA[MSB] == srcB[MSB]) && (sum[MSB] != srcA[MSB]);
    sub_ovf  = (srcA[MSB] != srcB[MSB]) && (diff[MSB] != srcA[MSB]);
    ror_res  = (srcA >> shamt) | (srcA << (5'(WIDTH) - {1'b0, shamt}));
    alu_res  = '0;
    alu_ovf  = 1'b0;
    is_arith = 1'b0;
    legal    = 1'b1;
    case (opcode)
      OP_ADD: begin
        alu_res  = add_ovf ? (srcA[MSB] ? SAT_NEG : SAT_POS) : sum;
        alu_ovf  = add_ovf;
        is_arith = 1'b1;
      end
      OP_SUB: begin
        alu_res  = sub_ovf ? (srcA[MSB] ? SAT_NEG : SAT_POS) : diff;
        alu_ovf  = sub_ovf;
        is_arith = 1'b1;
      end
      OP_XOR:         alu_res = srcA ^ srcB;
      OP_SLL, OP_SRA: alu_res = shift_res;
      OP_ROR:         alu_res = ror_res;
      default:        legal   = 1'b0;
    endcase
  end

  // Next state: flush beats stall; flags move only on a valid legal instruction.
  always_comb begin
    ex_valid_d   = ex_valid_q;
    ex_result_d  = ex_result_q;
    ex_opcode_d  = ex_opcode_q;
    zf_d         = zf_q;
    vf_d         = vf_q;
    nf_d         = nf_q;
    illegal_op_d = illegal_op_q;
    if (flush || (!stall && !id_valid)) begin
      ex_valid_d   = 1'b0;
      ex_result_d  = '0;
      illegal_op_d = 1'b0;
    end else if (!stall) begin
      ex_valid_d   = 1'b1;
      ex_opcode_d  = opcode;
      illegal_op_d = !legal;
      ex_result_d  = legal ? alu_res : '0;
      if (legal) begin
        zf_d = (alu_res == '0);
        if (is_arith) begin
          vf_d = alu_ovf;
          nf_d = alu_res[MSB];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q   <= 1'b0;
      ex_result_q  <= '0;
      ex_opcode_q  <= '0;
      zf_q         <= 1'b0;
      vf_q         <= 1'b0;
      nf_q         <= 1'b0;
      illegal_op_q <= 1'b0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      ex_result_q  <= ex_result_d;
      ex_opcode_q  <= ex_opcode_d;
      zf_q         <= zf_d;
      vf_q         <= vf_d;
      nf_q         <= nf_d;
      illegal_op_q <= illegal_op_d;
    end
  end

  assign ex_valid   = ex_valid_q;
  assign ex_result  = ex_result_q;
  assign ex_opcode  = ex_opcode_q;
  assign ZF         = zf_q;
  assign VF         = vf_q;
  assign NF         = nf_q;
  assign illegal_op = illegal_op_q;

endmodule

// File: tb/tb_alu_ex_stage.sv
// Bench for alu_ex_stage: a behavioural model pushes expected stage state into a queue
// as each cycle is driven; every test task pops and compares after the edge.

module tb_alu_ex_stage;

  typedef struct packed {
    logic        valid;
    logic [15:0] res;
    logic [3:0]  opc;
    logic        z;
    logic        v;
    logic        n;
    logic        ill;
  } out_t;

  logic        clk = 1'b0;
  logic        rst, stall, flush, id_valid;
  logic [3:0]  opcode, shamt;
  logic [15:0] srcA, srcB;
  logic        ex_valid, ZF, VF, NF, illegal_op;
  logic [15:0] ex_result;
  logic [3:0]  ex_opcode;

  int   n_checks = 0;
  int   n_fail   = 0;
  out_t m;
  out_t sb[$];
  out_t got, exp_o;

  alu_ex_stage #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
    .opcode(opcode), .srcA(srcA), .srcB(srcB), .shamt(shamt),
    .ex_valid(ex_valid), .ex_result(ex_result), .ex_opcode(ex_opcode),
    .ZF(ZF), .VF(VF), .NF(NF), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  function automatic out_t observed();
    return {ex_valid, ex_result, ex_opcode, ZF, VF, NF, illegal_op};
  endfunction

  // Reference behaviour of one clock edge, computed with wide signed integers.
  task automatic model_edge(input logic r, input logic f, input logic s, input logic v,
                            input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                            input logic [3:0] sh);
    int          t;
    logic [15:0] res, rr;
    logic        ovf;
    if (r) begin
      m = '0;
    end else if (f || (!s && !v)) begin
      m.valid = 1'b0; m.res = 16'h0; m.ill = 1'b0;
    end else if (!s) begin
      m.valid = 1'b1; m.opc = op; m.ill = 1'b0; ovf = 1'b0; res = 16'h0;
      case (op)
        4'h0, 4'h1: begin
          t = (op == 4'h0) ? int'($signed(a)) + int'($signed(b)) : int'($signed(a)) - int'($signed(b));
          if (t > 32767)       begin res = 16'h7FFF; ovf = 1'b1; end
          else if (t < -32768) begin res = 16'h8000; ovf = 1'b1; end
          else                 res = t[15:0];
          m.v = ovf; m.n = res[15];
        end
        4'h2: res = a ^ b;
        4'h4: res = a << sh;
        4'h5: res = 16'($signed(a) >>> sh);
        4'h6: begin
          rr = a;
          for (int i = 0; i < int'(sh); i++) rr = {rr[0], rr[15:1]};
          res = rr;
        end
        default: m.ill = 1'b1;
      endcase
      m.res = res;
      if (!m.ill) m.z = (res == 16'h0);
    end
  endtask

  task automatic apply(input logic r, input logic f, input logic s, input logic v,
                       input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] sh);
    rst = r; flush = f; stall = s; id_valid = v;
    opcode = op; srcA = a; srcB = b; shamt = sh;
    model_edge(r, f, s, v, op, a, b, sh);
    sb.push_back(m);
    @(posedge clk); #1;
  endtask

  task automatic test_reset(input string tag);
    for (int i = 0; i < 2; i++) begin
      apply(1'b1, 1'b1, 1'b1, 1'b1, 4'h0, 16'h7FFF, 16'h0001, 4'h3);
      got = observed(); exp_o = sb.pop_front(); n_checks++;
      if (got !== exp_o) begin
        n_fail++;
        $display("FAIL %s[%0d]: got v=%b r=%h op=%h zvn=%b%b%b ill=%b, expected v=%b r=%h op=%h zvn=%b%b%b ill=%b",
                 tag, i, got.valid, got.res, got.opc, got.z, got.v, got.n, got.ill,
                 exp_o.valid, exp_o.res, exp_o.opc, exp_o.z, exp_o.v, exp_o.n, exp_o.ill);
      end
    end
  endtask

  task automatic test_add_sat();
    logic [3:0]  ops[6] = '{4'h0, 4'h1, 4'h0, 4'h0, 4'h1, 4'h1};
    logic [15:0] as[6]  = '{16'h7FFF, 16'h8000, 16'h0005, 16'h8000, 16'h7FFF, 16'h0003};
    logic [15:0] bs[6]  = '{16'h0001, 16'h0001, 16'h0003, 16'hFFFF, 16'hFFFF, 16'h0005};
    for (int i = 0; i < 6; i++) begin
      apply(1'b0, 1'b0, 1'b0, 1'b1, ops[i], as[i], bs[i], 4'h0);
      got = observed(); exp_o = sb.pop_front(); n_checks++;
      if (got !== exp_o) begin
        n_fail++;
        $display("FAIL add_sat[%0d]: got v=%b r=%h op=%h zvn=%b%b%b ill=%b, expected v=%b r=%h op=%h zvn=%b%b%b ill=%b",
                 i, got.valid, got.res, got.opc, got.z, got.v, got.n, got.ill,
                 exp_o.valid, exp_o.res, exp_o.opc, exp_o.z, exp_o.v, exp_o.n, exp_o.ill);
      end
    end
  endtask

  task automatic test_shifts();
    logic [3:0]  ops[7] = '{4'h4, 4'h5, 4'h6, 4'h5, 4'h6, 4'h4, 4'h5};
    logic [15:0] as[7]  = '{16'h00F1, 16'h8F00, 16'h1234, 16'h8000, 16'hBEEF, 16'h8001, 16'h7F00};
    logic [3:0]  shs[7] = '{4'd4, 4'd4, 4'd4, 4'd15, 4'd0, 4'd1, 4'd15};
    for (int i = 0; i < 7; i++) begin
      apply(1'b0, 1'b0, 1'b0, 1'b1, ops[i], as[i], 16'hFFFF, shs[i]);
      got = observed(); exp_o = sb.pop_front(); n_checks++;
      if (got !== exp_o) begin
        n_fail++;
        $display("FAIL shifts[%0d]: got v=%b r=%h op=%h zvn=%b%b%b ill=%b, expected v=%b r=%h op=%h zvn=%b%b%b ill=%b",
                 i, got.valid, got.res, got.opc, got.z, got.v, got.n, got.ill,
                 exp_o.valid, exp_o.res, exp_o.opc, exp_o.z, exp_o.v, exp_o.n, exp_o.ill);
      end
    end
  endtask

  task automatic test_zero();
    logic [3:0]  ops[3] = '{4'h0, 4'h2, 4'h1};
    logic [15:0] as[3]  = '{16'h7FFF, 16'hA5A5, 16'h0005};
    logic [15:0] bs[3]  = '{16'h0001, 16'hA5A5, 16'h0005};
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 1'b0, 1'b0, 1'b1, ops[i], as[i], bs[i], 4'h0);
      got = observed(); exp_o = sb.pop_front(); n_checks++;
      if (got !== exp_o) begin
        n_fail++;
        $display("FAIL zero[%0d]: got v=%b r=%h op=%h zvn=%b%b%b ill=%b, expected v=%b r=%h op=%h zvn=%b%b%b ill=%b",
                 i, got.valid, got.res, got.opc, got.z, got.v, got.n, got.ill,
                 exp_o.valid, exp_o.res, exp_o.opc, exp_o.z, exp_o.v, exp_o.n, exp_o.ill);
      end
    end
  endtask

  // ADD 1+2, three stalled cycles with changing inputs, stall+flush, then an idle advance.
  task automatic test_stall_flush();
    logic s, f, v;
    for (int i = 0; i < 6; i++) begin
      s = (i >= 1 && i <= 4);
      f = (i == 4);
      v = (i != 5);
      if (i == 0) apply(1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 16'h0001, 16'h0002, 4'h0);
      else        apply(1'b0, f, s, v, 4'(i), 16'h8000 + 16'(i), 16'h8000, 4'(i));
      got = observed(); exp_o = sb.pop_front(); n_checks++;
      if (got !== exp_o) begin
        n_fail++;
        $display("FAIL stall_flush[%0d]: got v=%b r=%h op=%h zvn=%b%b%b ill=%b, expected v=%b r=%h op=%h zvn=%b%b%b ill=%b",
                 i, got.valid, got.res, got.opc, got.z, got.v, got.n, got.ill,
                 exp_o.valid, exp_o.res, exp_o.opc, exp_o.z, exp_o.v, exp_o.n, exp_o.ill);
      end
    end
  endtask

  task automatic test_illegal();
    logic [3:0] ops[5] = '{4'hF, 4'h3, 4'h7, 4'h0, 4'h8};
    logic       vs[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      apply(1'b0, 1'b0, 1'b0, vs[i], ops[i], 16'h1234, 16'h0001, 4'h2);
      got = observed(); exp_o = sb.pop_front(); n_checks++;
      if (got !== exp_o) begin
        n_fail++;
        $display("FAIL illegal[%0d]: got v=%b r=%h op=%h zvn=%b%b%b ill=%b, expected v=%b r=%h op=%h zvn=%b%b%b ill=%b",
                 i, got.valid, got.res, got.opc, got.z, got.v, got.n, got.ill,
                 exp_o.valid, exp_o.res, exp_o.opc, exp_o.z, exp_o.v, exp_o.n, exp_o.ill);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] op_pool[8] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h6, 4'h3, 4'hF};
    logic [15:0] a, b;
    for (int i = 0; i < 60; i++) begin
      a = 16'($urandom_range(0, 65535));
      b = (i % 7 == 0) ? a : 16'($urandom_range(0, 65535));
      apply(1'b0, ($urandom_range(0, 9) == 0), ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 4) != 0), op_pool[$urandom_range(0, 7)], a, b,
            4'($urandom_range(0, 15)));
      got = observed(); exp_o = sb.pop_front(); n_checks++;
      if (got !== exp_o) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: got v=%b r=%h op=%h zvn=%b%b%b ill=%b, expected v=%b r=%h op=%h zvn=%b%b%b ill=%b",
                 i, got.valid, got.res, got.opc, got.z, got.v, got.n, got.ill,
                 exp_o.valid, exp_o.res, exp_o.opc, exp_o.z, exp_o.v, exp_o.n, exp_o.ill);
      end
    end
  endtask

  initial begin
    m = '0;
    rst = 1'b1; stall = 1'b0; flush = 1'b0; id_valid = 1'b0;
    opcode = 4'h0; srcA = 16'h0; srcB = 16'h0; shamt = 4'h0;
    test_reset("reset");
    test_add_sat();
    test_shifts();
    test_zero();
    test_stall_flush();
    test_illegal();
    test_back_to_back();
    test_add_sat();
    test_reset("reset_late");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_ex_stage.md
Name: alu_ex_stage

Overview:
- Single-cycle execute stage for the 16-bit WISC CPU datapath, between the ID/EX operands and the EX/MEM boundary.
- Instantiates the existing 16-bit Shifter for SLL/SRA, adds saturating ADD/SUB, XOR and ROR, and registers the result.
- Owns the architectural flag register (Z, V, N) and updates it according to the opcode.
- Supports pipeline stall (hold) and flush (bubble insertion).

Parameters:
- WIDTH, 16, datapath width; only 16 is supported because the Shifter is fixed at 16 bits.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- stall  input  1  hold all stage state this cycle
- flush  input  1  replace the registered instruction with a bubble
- id_valid  input  1  the ID/EX operands hold a real instruction
- opcode  input  4  0000 ADD, 0001 SUB, 0010 XOR, 0100 SLL, 0101 SRA, 0110 ROR; any other value is illegal
- srcA  input  16  first operand, or the value to shift
- srcB  input  16  second operand for ADD/SUB/XOR
- shamt  input  4  shift/rotate amount, 0-15
- ex_valid  output  1  registered result is a real instruction
- ex_result  output  16  registered ALU result
- ex_opcode  output  4  registered opcode, passed to MEM/WB decode
- ZF  output  1  zero flag
- VF  output  1  overflow flag
- NF  output  1  negative flag
- illegal_op  output  1  registered; high for one valid cycle when an illegal opcode was accepted

Behaviour:
- Reset:
  - When rst=1 at a clock edge, ex_valid, ex_result, ex_opcode, ZF, VF, NF and illegal_op all go to 0.
  - Reset has the highest priority, including over stall and flush, and aborts any operation in progress.
- Priority per edge is rst > flush > stall > normal advance.
- Flush:
  - ex_valid <= 0, ex_result <= 0, illegal_op <= 0.
  - Flags hold their value; a flushed instruction never updates flags.
  - Flush wins over a simultaneous stall.
- Stall: every register holds its value, outputs included.
- Normal advance with id_valid=0: ex_valid <= 0, ex_result <= 0, flags hold.
- Normal advance with id_valid=1:
  - ex_valid <= 1, ex_opcode <= opcode.
  - ex_result <= the computed value; latency is exactly 1 cycle.
- Arithmetic rules:
  - ADD: signed 16-bit add with saturation. A positive overflow gives 0x7FFF and a negative overflow gives 0x8000.
  - SUB: srcA - srcB, saturated the same way.
  - XOR: srcA ^ srcB.
  - SLL: Shifter with Mode=0, Shift_In=srcA, Shift_Val=shamt. Zeros fill from the LSB.
  - SRA: Shifter with Mode=1, Shift_In=srcA, Shift_Val=shamt. The sign bit fills from the MSB.
  - ROR: rotate srcA right by shamt; shamt=0 returns srcA unchanged.
  - Illegal opcode: ex_result <= 0, illegal_op <= 1, flags hold.
- Flag update, applied only on a valid legal accepted instruction:
  - ADD/SUB update Z, V and N. V=1 exactly when saturation occurred. N is the MSB of the saturated result. Z=(result==0).
  - XOR/SLL/SRA/ROR update Z only; V and N hold.
- Flag visibility: flags change on the same edge that registers ex_result, so they are visible one cycle after acceptance.
- The stage has no internal pipelining and keeps no state beyond the registers listed here.

Test Plan:
- Reset: hold rst=1 for 2 cycles with stall=1, flush=1 and id_valid=1 -> all outputs 0; ZF=VF=NF=0.
- ADD saturation: ADD srcA=0x7FFF, srcB=0x0001 -> next cycle ex_result=0x7FFF, VF=1, NF=0, ZF=0. Then SUB srcA=0x8000, srcB=0x0001 -> ex_result=0x8000, VF=1, NF=1.
- Shifts:
  - SLL srcA=0x00F1, shamt=4 -> 0x0F10.
  - SRA srcA=0x8F00, shamt=4 -> 0xF8F0.
  - ROR srcA=0x1234, shamt=4 -> 0x4123.
  - SRA srcA=0x8000, shamt=15 -> 0xFFFF.
  - Across all four, only ZF changes (stays 0); VF and NF keep their prior values.
- Zero result: XOR srcA=srcB=0xA5A5 after an overflowing ADD -> ex_result=0x0000, ZF=1, VF stays 1, NF stays as set by the ADD.
- Stall/flush:
  - Accept ADD 1+2 (ex_result=0x0003), then raise stall for 3 cycles while the inputs change -> ex_result stays 0x0003 and ex_valid stays 1.
  - Then assert stall=1 and flush=1 together -> ex_valid=0, ex_result=0, flags unchanged.
- Illegal opcode: opcode=1111 with id_valid=1 -> illegal_op=1 and ex_result=0 for one cycle, flags unchanged. The next valid ADD clears illegal_op.
